// File: rtl/gemm_cim_pkg.sv
// rtl/gemm_cim_pkg.sv - shared widths and lane dot-product helper for the CIM GEMM macro
//
// Purpose: lane geometry, accumulator width, output-select width, default
// weight depth and the signed lane multiply-and-sum used by cim_dot4.
// Ports: none (package).

package gemm_cim_pkg;

  localparam int LANES     = 4;
  localparam int LANE_W    = 8;
  localparam int WORD_W    = LANES * LANE_W;
  localparam int ACC_W     = 32;
  localparam int OUT_SEL_W = 4;
  localparam int NUM_OUT   = 1 << OUT_SEL_W;
  localparam int DEPTH_DEF = 64;

  typedef logic [ACC_W-1:0] acc_t;

  // Signed int8 x int8 per lane, each 16-bit product sign-extended to the
  // accumulator width before summing. The four-lane total fits in 18 bits,
  // so the 32-bit sum never wraps.
  function automatic acc_t dot4_sum(input logic [WORD_W-1:0] w,
                                    input logic [WORD_W-1:0] a);
    acc_t                    acc;
    logic signed [2*LANE_W-1:0] prod;
    acc = '0;
    for (int i = 0; i < LANES; i++) begin
      prod = $signed(w[i*LANE_W +: LANE_W]) * $signed(a[i*LANE_W +: LANE_W]);
      acc  = acc + {{(ACC_W-2*LANE_W){prod[2*LANE_W-1]}}, prod};
    end
    return acc;
  endfunction

endpackage

// File: rtl/cim_dot4.sv
// rtl/cim_dot4.sv - combinational 4-lane signed int8 dot product
//
// Purpose: dot of one packed weight word against one packed activation word.
// Ports:
//   weight_i  in  32  packed int8 weights, lane i = bits [8i+7:8i]
//   act_i     in  32  packed int8 activations, same lane layout
//   dot_o     out 32  sign-extended dot product

module cim_dot4
  import gemm_cim_pkg::*;
(
  input  logic [WORD_W-1:0] weight_i,
  input  logic [WORD_W-1:0] act_i,
  output logic [ACC_W-1:0]  dot_o
);

  assign dot_o = dot4_sum(weight_i, act_i);

endmodule

// File: rtl/basic_gemm_cim.sv
// rtl/basic_gemm_cim.sv - compute-in-memory GEMM macro with weight SRAM and 16 accumulators
//
// Purpose: stores packed int8 weight rows, computes 4-lane signed dot products
// against input_data and stores or accumulates them into selectable 32-bit
// output registers; cim_output is a registered readback of the selected one.
// Optional build macro: CIM_SATURATE_EN (accumulate saturates instead of wrapping).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cs                  chip select; low holds all state
//   web                 weight write enable, active-low
//   cimeb               compute enable, active-low
//   partial_sum_eb      0 = accumulate, 1 = overwrite
//   reset_output_reg    clear all output registers
//   output_reg [3:0]    destination / readback select
//   address [31:0]      weight row index (low log2(DEPTH) bits)
//   input_data [31:0]   write data or packed activations
//   cim_output [31:0]   readback of out[output_reg] before this edge's update

module basic_gemm_cim
  import gemm_cim_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 web,
  input  logic                 cimeb,
  input  logic                 partial_sum_eb,
  input  logic                 reset_output_reg,
  input  logic [OUT_SEL_W-1:0] output_reg,
  input  logic [31:0]          address,
  input  logic [WORD_W-1:0]    input_data,
  output logic [ACC_W-1:0]     cim_output
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  acc_t              out_q [NUM_OUT];
  acc_t              cim_output_q;

  logic [AW-1:0]     row_idx;
  logic [WORD_W-1:0] row_word;
  acc_t              dot;
  acc_t              cur;
  acc_t              sum;
  acc_t              acc_d;
  logic              unused_addr;

  assign row_idx     = address[AW-1:0];
  assign unused_addr = ^address[31:AW];
  // Combinational array read: a write lands at the edge, so a compute in the
  // following cycle already sees the new row.
  assign row_word    = mem_q[row_idx];
  assign cur         = out_q[output_reg];

  cim_dot4 u_dot4 (
    .weight_i (row_word),
    .act_i    (input_data),
    .dot_o    (dot)
  );

  always_comb begin
    sum   = cur + dot;
    acc_d = sum;
`ifdef CIM_SATURATE_EN
    // Overflow only when both operands share a sign the sum does not.
    if ((cur[ACC_W-1] == dot[ACC_W-1]) && (sum[ACC_W-1] != cur[ACC_W-1])) begin
      acc_d = cur[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
    if (partial_sum_eb) begin
      acc_d = dot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      for (int j = 0; j < NUM_OUT; j++) begin
        out_q[j] <= '0;
      end
      cim_output_q <= '0;
    end else if (cs) begin
      // Readback always samples the pre-update value, even on a clear.
      cim_output_q <= cur;
      if (reset_output_reg) begin
        for (int j = 0; j < NUM_OUT; j++) begin
          out_q[j] <= '0;
        end
      end else if (!web) begin
        mem_q[row_idx] <= input_data;
      end else if (!cimeb) begin
        out_q[output_reg] <= acc_d;
      end
    end
  end

  assign cim_output = cim_output_q;

endmodule

// File: tb/tb_basic_gemm_cim.sv
// tb/tb_basic_gemm_cim.sv - self-checking bench for basic_gemm_cim with reference model

module tb_basic_gemm_cim;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        web;
  logic        cimeb;
  logic        partial_sum_eb;
  logic        reset_output_reg;
  logic [3:0]  output_reg;
  logic [31:0] address;
  logic [31:0] input_data;
  logic [31:0] cim_output;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  logic [31:0] w_m [64];
  logic [31:0] o_m [16];
  logic [31:0] cout_m;

  basic_gemm_cim dut (
    .clk              (clk),
    .rst              (rst),
    .cs               (cs),
    .web              (web),
    .cimeb            (cimeb),
    .partial_sum_eb   (partial_sum_eb),
    .reset_output_reg (reset_output_reg),
    .output_reg       (output_reg),
    .address          (address),
    .input_data       (input_data),
    .cim_output       (cim_output)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int ref_dot(input logic [31:0] w, input logic [31:0] a);
    int  s;
    byte bw;
    byte ba;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      bw = w[8*i +: 8];
      ba = a[8*i +: 8];
      s  = s + int'(bw) * int'(ba);
    end
    return s;
  endfunction

  task automatic model_edge(input logic r, input logic c, input logic w, input logic ce,
                            input logic ps, input logic rro, input logic [3:0] sel,
                            input logic [31:0] a, input logic [31:0] d);
    longint t;
    int     dt;
    if (r) begin
      for (int i = 0; i < 64; i++) w_m[i] = 0;
      for (int i = 0; i < 16; i++) o_m[i] = 0;
      cout_m = 0;
    end else if (c) begin
      cout_m = o_m[sel];
      if (rro) begin
        for (int i = 0; i < 16; i++) o_m[i] = 0;
      end else if (!w) begin
        w_m[a[5:0]] = d;
      end else if (!ce) begin
        dt = ref_dot(w_m[a[5:0]], d);
        if (ps) begin
          o_m[sel] = dt;
        end else begin
          t = longint'($signed(o_m[sel])) + longint'(dt);
`ifdef CIM_SATURATE_EN
          if (t > 64'sd2147483647) t = 64'sd2147483647;
          if (t < -64'sd2147483648) t = -64'sd2147483648;
`endif
          o_m[sel] = t[31:0];
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic w, input logic ce,
                      input logic ps, input logic rro, input logic [3:0] sel,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; cs = c; web = w; cimeb = ce; partial_sum_eb = ps;
    reset_output_reg = rro; output_reg = sel; address = a; input_data = d;
    @(posedge clk);
    #1;
    model_edge(r, c, w, ce, ps, rro, sel, a, d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(0, 1, 0, 1, 1, 0, 4'd0, a, d);
  endtask

  task automatic comp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel,
                      input logic ps);
    step(0, 1, 1, 0, ps, 0, sel, a, d);
  endtask

  task automatic rd(input logic [3:0] sel);
    step(0, 1, 1, 1, 1, 0, sel, 32'h0, 32'h0);
  endtask

  task automatic expect_out(input string name, input logic [31:0] exp);
    checks++;
    if (cim_output !== exp) begin
      errors++;
      $display("FAIL %s: cim_output=%08h expected=%08h", name, cim_output, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (cim_output !== cout_m) begin
        errors++;
        $display("FAIL model_compare @%0t: cim_output=%08h expected=%08h",
                 $time, cim_output, cout_m);
      end
    end
  end

  initial begin
    rst = 1; cs = 0; web = 1; cimeb = 1; partial_sum_eb = 1;
    reset_output_reg = 0; output_reg = 0; address = 0; input_data = 0;

    step(1, 0, 1, 1, 1, 0, 4'd0, 32'h0, 32'h0);
    step(1, 0, 1, 1, 1, 0, 4'd0, 32'h0, 32'h0);
    chk_on = 1;
    expect_out("reset", 32'h0);

    comp(32'd9, 32'h01010101, 4'd1, 1);
    rd(4'd1);
    expect_out("zero_row_compute", 32'h0);

    wr(32'd3, 32'h01020304);
    comp(32'd3, 32'h01010101, 4'd5, 1);
    rd(4'd5);
    expect_out("write_compute", 32'h0000000A);

    wr(32'd7, 32'hFF000080);
    comp(32'd7, 32'h80000080, 4'd2, 1);
    rd(4'd2);
    expect_out("signed_overwrite", 32'h00004080);
    comp(32'd7, 32'h80000080, 4'd2, 0);
    rd(4'd2);
    expect_out("signed_accumulate", 32'h00008100);

    step(0, 1, 0, 0, 1, 0, 4'd5, 32'd3, 32'h05050505);
    expect_out("write_wins_readback", 32'h0000000A);
    rd(4'd5);
    expect_out("write_wins_no_compute", 32'h0000000A);
    comp(32'd3, 32'h01010101, 4'd6, 1);
    rd(4'd6);
    expect_out("write_wins_new_row", 32'h00000014);

    step(0, 1, 0, 0, 1, 1, 4'd6, 32'd3, 32'h0);
    expect_out("clear_reads_pre_value", 32'h00000014);
    for (int r = 0; r < 16; r++) begin
      rd(r[3:0]);
      expect_out($sformatf("cleared_reg%0d", r), 32'h0);
    end
    comp(32'd3, 32'h01010101, 4'd6, 1);
    rd(4'd6);
    expect_out("clear_suppresses_write", 32'h00000014);

    step(0, 0, 0, 0, 0, 0, 4'd7, 32'd3, 32'h11111111);
    expect_out("cs_low_holds_output", 32'h00000014);
    rd(4'd6);
    expect_out("cs_low_holds_acc", 32'h00000014);
    comp(32'hFFFF_FFC3, 32'h01010101, 4'd6, 1);
    rd(4'd6);
    expect_out("cs_low_holds_weight_upper_addr_ignored", 32'h00000014);

    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 127) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 0),
           $urandom_range(0, 1), ($urandom_range(0, 31) == 0),
           4'($urandom_range(0, 15)), $urandom, $urandom);
    end

    wr(32'd10, 32'h80808080);
    wr(32'd13, 32'h7F7F7F7F);
    wr(32'd12, 32'h00000264);
    wr(32'd11, 32'h017F7F7F);
    comp(32'd10, 32'h80808080, 4'd0, 1);
    for (int n = 0; n < 32766; n++) begin
      comp(32'd10, 32'h80808080, 4'd0, 0);
    end
    comp(32'd13, 32'h7F7F7F7F, 4'd0, 0);
    comp(32'd12, 32'h0000020A, 4'd0, 0);
    rd(4'd0);
    expect_out("preload", 32'h7FFFFFF0);
    comp(32'd11, 32'h01027F7F, 4'd0, 0);
    rd(4'd0);
`ifdef CIM_SATURATE_EN
    expect_out("overflow_saturate", 32'h7FFFFFFF);
`else
    expect_out("overflow_wrap", 32'h80007EF1);
`endif

    @(negedge clk);
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
